sram_arbiter: RTL

- Shares one single-read/single-write sram instance between two requesters.
- Port I is instruction fetch (read-only); port D is load/store (read/write, with lock).
- Serializes at most one sram command per cycle, round-robin fair, with a bounded lock that lets D do an atomic read-modify-write.
- Sits between the fetch/memory stages and the sram; read latency through the block is 1 cycle.

---
 rtl/sram_arbiter_pkg.sv | 16 +
 rtl/sram_arbiter_rr_pick2.sv | 35 +++
 rtl/sram_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared encodings for the two-port sram arbiter: lock FSM states and requester indices.
package sram_arbiter_pkg;

  typedef enum logic {
    ARB_OPEN   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  localparam int ARB_PORT_I = 0;
  localparam int ARB_PORT_D = 1;

  function automatic int lock_cnt_width(input int lock_max);
    return $clog2(lock_max + 1);
  endfunction

endpackage

// File: rtl/sram_arbiter_rr_pick2.sv
// Two-way round-robin pick; the pointer moves past the winner whenever i_en is high.
module sram_arbiter_rr_pick2
  import sram_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  logic r_ptr_d;
  logic w_pick_d;

  always_comb begin
    if (i_req[ARB_PORT_I] && i_req[ARB_PORT_D]) begin
      w_pick_d = r_ptr_d;
    end else begin
      w_pick_d = i_req[ARB_PORT_D];
    end
  end

  assign o_gnt[ARB_PORT_I] = i_req[ARB_PORT_I] & ~w_pick_d;
  assign o_gnt[ARB_PORT_D] = i_req[ARB_PORT_D] &  w_pick_d;

  // Last winner drops to lowest priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr_d <= 1'b0;
    end else if (i_en && (o_gnt != 2'b00)) begin
      r_ptr_d <= o_gnt[ARB_PORT_I];
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one 1R/1W sram between instruction fetch (I) and load/store (D) with a bounded D lock.
//   state      | meaning
//   ARB_OPEN   | round-robin between I and D
//   ARB_LOCKED | D owns the sram; I is held off until unlock or LOCK_MAX cycles
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter  int DEPTH    = 1024,
  parameter  int LOCK_MAX = 8,
  localparam int LOGDEPTH = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_req,
  input  logic [LOGDEPTH-1:0] i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [31:0]         i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [LOGDEPTH-1:0] d_addr,
  input  logic [3:0]          d_byte_en,
  input  logic [31:0]         d_wdata,
  input  logic                d_lock,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [31:0]         d_rdata,
  output logic                sram_read_req,
  output logic [LOGDEPTH-1:0] sram_read_addr,
  input  logic [31:0]         sram_read_data,
  output logic                sram_write_req,
  output logic [LOGDEPTH-1:0] sram_write_addr,
  output logic [3:0]          sram_write_byte_en,
  output logic [31:0]         sram_write_data
);

  localparam int CNT_W = lock_cnt_width(LOCK_MAX);

  arb_state_e       r_state;
  arb_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_lock_cnt;
  logic [1:0]       w_req;
  logic [1:0]       w_gnt;
  logic             w_lock_expire;
  logic             r_i_rvalid;
  logic             r_d_rvalid;

  assign w_req[ARB_PORT_I] = i_req & (r_state == ARB_OPEN);
  assign w_req[ARB_PORT_D] = d_req;

  sram_arbiter_rr_pick2 u_pick (
    .clk     (clk),
    .reset_n (reset_n),
    .i_en    (1'b1),
    .i_req   (w_req),
    .o_gnt   (w_gnt)
  );

  assign i_gnt = w_gnt[ARB_PORT_I];
  assign d_gnt = w_gnt[ARB_PORT_D];

  // Counter reaches LOCK_MAX on the same edge that forces the lock open.
  assign w_lock_expire = (r_lock_cnt == CNT_W'(LOCK_MAX - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ARB_OPEN;
      r_lock_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ARB_OPEN) begin
        r_lock_cnt <= '0;
      end else if (r_lock_cnt != CNT_W'(LOCK_MAX)) begin
        r_lock_cnt <= r_lock_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_OPEN:   if (d_gnt && d_lock) w_state_nxt = ARB_LOCKED;
      ARB_LOCKED: if ((d_gnt && !d_lock) || w_lock_expire) w_state_nxt = ARB_OPEN;
      default:    w_state_nxt = ARB_OPEN;
    endcase
  end

  always_comb begin
    sram_read_req      = 1'b0;
    sram_read_addr     = '0;
    sram_write_req     = 1'b0;
    sram_write_addr    = '0;
    sram_write_byte_en = '0;
    sram_write_data    = '0;
    if (i_gnt) begin
      sram_read_req  = 1'b1;
      sram_read_addr = i_addr;
    end else if (d_gnt && !d_we) begin
      sram_read_req  = 1'b1;
      sram_read_addr = d_addr;
    end else if (d_gnt && d_we) begin
      sram_write_req     = 1'b1;
      sram_write_addr    = d_addr;
      sram_write_byte_en = d_byte_en;
      sram_write_data    = d_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_i_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
    end else begin
      r_i_rvalid <= i_gnt;
      r_d_rvalid <= d_gnt & ~d_we;
    end
  end

  assign i_rvalid = r_i_rvalid;
  assign d_rvalid = r_d_rvalid;
  assign i_rdata  = sram_read_data;
  assign d_rdata  = sram_read_data;

endmodule
